ahb_lite_master: RTL
====================

Name: ahb_lite_master

Overview:
- Single-master AHB-Lite initiator.
- Converts a valid/ready load/store request stream from the RV32I core into pipelined AHB-Lite SINGLE transfers on the shared bus (GPIO and memory slaves).
- Returns one registered response per request, in order, with read data and an error flag.
- Overlaps the address phase of request N+1 with the data phase of request N, giving one transfer per cycle at zero wait states.

Parameters:
- DATA_WIDTH, 32, width of hwdata/hrdata/req_wdata/rsp_rdata.
- ADDR_WIDTH, 32, width of haddr/req_addr.
- HPROT_VAL, 4'b0011, constant driven on hprot (non-cacheable, non-bufferable, privileged, data).

Ports:
- HCLK  in  1  bus clock
- HRESETn  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid & req_ready at posedge
- req_write  in  1  1=store, 0=load
- req_addr  in  ADDR_WIDTH  byte address, forwarded unchanged
- req_size  in  3  AHB hsize encoding; must not exceed DATA_WIDTH
- req_wdata  in  DATA_WIDTH  store data, already lane-aligned
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  DATA_WIDTH  hrdata captured for loads, 0 for stores
- rsp_error  out  1  slave returned ERROR
- haddr  out  ADDR_WIDTH  address phase
- htrans  out  2  IDLE 2'b00 / NONSEQ 2'b10 only
- hwrite  out  1  address-phase direction
- hsize  out  3  address-phase size
- hburst  out  3  constant 3'b000 (SINGLE)
- hprot  out  4  constant HPROT_VAL
- hmastlock  out  1  constant 0
- hwdata  out  DATA_WIDTH  data-phase write data
- hrdata  in  DATA_WIDTH  read data
- hready  in  1  transfer/phase completes
- hresp  in  1  0=OKAY, 1=ERROR

Behaviour:
- Reset (async, HRESETn=0): ap_valid=0, dp_valid=0, hold_valid=0, htrans=IDLE, haddr/hsize/hwrite/hwdata=0, rsp_valid=0, rsp_rdata=0, rsp_error=0. Any in-flight transfer is discarded with no response. Reset release at any point yields IDLE on the next edge.
- Registers:
  - AP (address phase): ap_valid, addr, size, write, wdata. htrans=NONSEQ iff ap_valid and the cancel flag is clear.
  - DP (data phase): dp_valid, write, wdata. hwdata = dp_wdata when dp_valid, else 0.
- Accept (combinational): req_ready = (~ap_valid | hready) & ~hold_valid & ~(hresp & ~hready).
- At a posedge with hready=1:
  - If dp_valid: rsp_valid<=1, rsp_error<=hresp, rsp_rdata<=(dp_write?0:hrdata).
  - DP<=AP if AP was issued (NONSEQ), else dp_valid<=0.
  - AP<=accepted request, or ap_valid<=0 if none.
- At a posedge with hready=0: AP and DP hold, rsp_valid<=0; haddr/hwdata stay stable.
- Latency: accept at edge T, NONSEQ during cycle T+1, data phase T+2, rsp_valid during cycle T+3 (zero wait). Sustained throughput is 1 per cycle. Each wait state adds 1 cycle.
- Two-cycle ERROR:
  - On a posedge with hresp=1 & hready=0 while ap_valid: copy AP into the hold slot, set hold_valid, and drive htrans=IDLE next cycle (legal cancel).
  - On the second ERROR cycle (hready=1): the DP response is rsp_error=1. DP does not load the cancelled AP.
  - On the next edge: the held request is reissued as NONSEQ and hold_valid clears.
  - The cancelled request is never lost or duplicated, and its response keeps program order.
- Single-cycle ERROR (hresp=1 with hready=1, produced by zero-wait slaves): completes the data phase with rsp_error=1; the pipelined AP proceeds normally.
- Responses are strictly in request order; at most 2 requests are outstanding (AP+DP).
- No alignment or size checking; the slave's hresp is authoritative.

Test Plan:
- Single write then read, zero-wait slave: write 0x4 data 0x0000_00A5 hsize=010, then read 0x4 -> htrans NONSEQ one cycle after each accept; hwdata=0xA5 in the write data phase; read rsp_rdata=0x0000_00A5 on the 3rd cycle after accept, rsp_error=0.
- Back-to-back 4 reads 0x0,0x4,0x8,0xC with req_valid held -> 4 consecutive NONSEQ cycles, 4 consecutive rsp_valid pulses, in order, no bubbles.
- Wait states: slave holds hready=0 for 2 cycles on read 0x8 -> haddr=0x8 next-phase address and DP stable; req_ready=0 while stalled; response arrives 2 cycles later.
- Two-cycle ERROR on write 0xC with read 0x0 pipelined -> htrans=IDLE in the 2nd error cycle; write response rsp_error=1; read 0x0 reissued as NONSEQ next cycle and completes OKAY.
- Single-cycle ERROR (hresp=1, hready=1) on write 0x0 -> rsp_error=1; the following pipelined request completes normally with no IDLE inserted.
- Assert HRESETn=0 mid data phase with 2 outstanding -> next cycle htrans=IDLE, rsp_valid=0; no response is ever produced for the discarded requests.

Source files
------------

// File: rtl/ahb_lite_master_if.sv
// Request/response stream and AHB-Lite bus signals of the single-master initiator.
// The master modport is the initiator's view; the slave modport is the core/bus side.
interface ahb_lite_master_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) ();
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [2:0]            req_size;
  logic [DATA_WIDTH-1:0] req_wdata;

  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_error;

  logic [ADDR_WIDTH-1:0] haddr;
  logic [1:0]            htrans;
  logic                  hwrite;
  logic [2:0]            hsize;
  logic [2:0]            hburst;
  logic [3:0]            hprot;
  logic                  hmastlock;
  logic [DATA_WIDTH-1:0] hwdata;
  logic [DATA_WIDTH-1:0] hrdata;
  logic                  hready;
  logic                  hresp;

  modport master (
    input  req_valid, req_write, req_addr, req_size, req_wdata,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_error,
    output haddr, htrans, hwrite, hsize, hburst, hprot, hmastlock, hwdata,
    input  hrdata, hready, hresp
  );

  modport slave (
    output req_valid, req_write, req_addr, req_size, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_error,
    input  haddr, htrans, hwrite, hsize, hburst, hprot, hmastlock, hwdata,
    output hrdata, hready, hresp
  );
endinterface

// File: rtl/ahb_lite_master.sv
// Pipelined AHB-Lite SINGLE-transfer initiator: address phase of request N+1 overlaps
// the data phase of request N; one in-order registered response per request.
module ahb_lite_master #(
  parameter int         DATA_WIDTH = 32,
  parameter int         ADDR_WIDTH = 32,
  parameter logic [3:0] HPROT_VAL  = 4'b0011
) (
  input logic               HCLK,
  input logic               HRESETn,
  ahb_lite_master_if.master bus
);

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_NONSEQ = 2'b10
  } htrans_e;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [2:0]            size;
    logic                  write;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  req_t                  req_in;
  req_t                  ap_q, ap_d;
  req_t                  hold_q, hold_d;
  logic                  ap_valid_q, ap_valid_d;
  logic                  cancel_q, cancel_d;
  logic                  hold_valid_q, hold_valid_d;
  logic                  dp_valid_q, dp_valid_d;
  logic                  dp_write_q, dp_write_d;
  logic [DATA_WIDTH-1:0] dp_wdata_q, dp_wdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_error_q, rsp_error_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

  logic                  err_first;
  logic                  ap_issued;
  logic                  accept;

  assign req_in = '{addr:  bus.req_addr,
                    size:  bus.req_size,
                    write: bus.req_write,
                    wdata: bus.req_wdata};

  // First cycle of a two-cycle ERROR response.
  assign err_first     = bus.hresp & ~bus.hready;
  assign ap_issued     = ap_valid_q & ~cancel_q;
  assign bus.req_ready = (~ap_valid_q | bus.hready) & ~hold_valid_q & ~err_first;
  assign accept        = bus.req_valid & bus.req_ready;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    ap_d         = ap_q;
    ap_valid_d   = ap_valid_q;
    cancel_d     = cancel_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    dp_valid_d   = dp_valid_q;
    dp_write_d   = dp_write_q;
    dp_wdata_d   = dp_wdata_q;
    rsp_valid_d  = 1'b0;
    rsp_error_d  = rsp_error_q;
    rsp_rdata_d  = rsp_rdata_q;

    if (bus.hready) begin
      if (dp_valid_q) begin
        rsp_valid_d = 1'b1;
        rsp_error_d = bus.hresp;
        rsp_rdata_d = dp_write_q ? '0 : bus.hrdata;
      end

      // A cancelled address phase never reaches the data phase.
      dp_valid_d = ap_issued;
      if (ap_issued) begin
        dp_write_d = ap_q.write;
        dp_wdata_d = ap_q.wdata;
      end

      cancel_d = 1'b0;
      if (hold_valid_q) begin
        ap_valid_d   = 1'b1;
        ap_d         = hold_q;
        hold_valid_d = 1'b0;
      end else if (accept) begin
        ap_valid_d = 1'b1;
        ap_d       = req_in;
      end else begin
        ap_valid_d = 1'b0;
      end
    end else begin
      if (err_first && ap_valid_q && !hold_valid_q) begin
        hold_d       = ap_q;
        hold_valid_d = 1'b1;
        cancel_d     = 1'b1;
      end
      // An empty address slot may be filled while the data phase is stalled.
      if (accept) begin
        ap_valid_d = 1'b1;
        ap_d       = req_in;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ap_q         <= '0;
      ap_valid_q   <= 1'b0;
      cancel_q     <= 1'b0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      dp_valid_q   <= 1'b0;
      dp_write_q   <= 1'b0;
      dp_wdata_q   <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_error_q  <= 1'b0;
      rsp_rdata_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      ap_q         <= ap_d;
      ap_valid_q   <= ap_valid_d;
      cancel_q     <= cancel_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      dp_valid_q   <= dp_valid_d;
      dp_write_q   <= dp_write_d;
      dp_wdata_q   <= dp_wdata_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_error_q  <= rsp_error_d;
      rsp_rdata_q  <= rsp_rdata_d;
    end
  end

  assign bus.htrans    = ap_issued ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign bus.haddr     = ap_q.addr;
  assign bus.hwrite    = ap_q.write;
  assign bus.hsize     = ap_q.size;
  assign bus.hburst    = 3'b000;
  assign bus.hprot     = HPROT_VAL;
  assign bus.hmastlock = 1'b0;
  assign bus.hwdata    = dp_valid_q ? dp_wdata_q : '0;

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_error = rsp_error_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule
